lcd_window_scanner: RTL and testbench

- Parametrised LCD raster generator with an integer-scaled framebuffer window; next generation of our 480x272 panel timing plus video_ram read path.
- Timing, window geometry, scale and RAM latency are parameters; adds runtime display modes, a solid background colour and a frame-start strobe.
- All outputs are aligned through a pipeline that compensates for RAM read latency.
- Sits between the pixel-clock PLL output, video_ram (read port) and the LCD pins.

---
 rtl/lcd_window_scanner_if.sv | 29 ++
 rtl/lcd_window_scanner.sv | 153 +++++++++++++++
 tb/tb_lcd_window_scanner.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_window_scanner_if.sv
// Video RAM read port and LCD pin group of the window scanner.
// The scanner side uses master; the RAM/panel side uses slave.
interface lcd_window_scanner_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              lcd_hsync;
    logic              lcd_vsync;
    logic              lcd_den;
    logic [4:0]        lcd_r;
    logic [5:0]        lcd_g;
    logic [4:0]        lcd_b;
    logic              frame_start;

    modport master (
        output rd_en, rd_addr, lcd_hsync, lcd_vsync, lcd_den,
               lcd_r, lcd_g, lcd_b, frame_start,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, lcd_hsync, lcd_vsync, lcd_den,
               lcd_r, lcd_g, lcd_b, frame_start,
        output rd_data
    );
endinterface

// File: rtl/lcd_window_scanner.sv
// LCD raster generator with an integer-scaled framebuffer window; every output is
// delayed by 2+RAM_LAT clocks so syncs, den and pixels line up with the RAM data.
module lcd_window_scanner #(
    parameter int H_ACTIVE   = 480,
    parameter int H_BP       = 43,
    parameter int H_FP       = 8,
    parameter int H_PULSE    = 4,
    parameter int V_ACTIVE   = 272,
    parameter int V_BP       = 12,
    parameter int V_FP       = 8,
    parameter int V_PULSE    = 4,
    parameter int WIN_X      = 160,
    parameter int WIN_Y      = 8,
    parameter int WIN_W_LOG2 = 6,
    parameter int WIN_H_LOG2 = 6,
    parameter int SCALE_LOG2 = 2,
    parameter int DATA_W     = 8,
    parameter int RAM_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           mode,
    input  logic [15:0]          bg_color,
    lcd_window_scanner_if.master bus
);
    localparam int H_TOTAL  = H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL  = V_BP + V_ACTIVE + V_FP;
    localparam int HC_W     = $clog2(H_TOTAL);
    localparam int VC_W     = $clog2(V_TOTAL);
    localparam int WIN_PX_W = (1 << WIN_W_LOG2) << SCALE_LOG2;
    localparam int WIN_PX_H = (1 << WIN_H_LOG2) << SCALE_LOG2;
    // Control word: {frame_start, hsync, vsync, den, in_win}; idle keeps syncs high.
    localparam logic [4:0] CTRL_IDLE = 5'b01100;

    function automatic logic [15:0] grey_to_rgb565(input logic [5:0] top);
        return {top[5:1], top, top[5:1]};
    endfunction

    logic [HC_W-1:0] h_cnt_p0;
    logic [VC_W-1:0] v_cnt_p0;
    logic [15:0]     x_p0, y_p0, x_off_p0, y_off_p0;
    logic            hs_p0, vs_p0, den_p0, win_p0, fs_p0;
    logic [1:0]      mode_q;
    logic [15:0]     bg_q;
    logic [4:0]      ctrl_p1;
    logic [15:0]     pat_p1;
    logic [4:0]      ctrl_p2 [RAM_LAT];
    logic [15:0]     pat_p2  [RAM_LAT];
    logic [4:0]      ctrl_last;
    logic [15:0]     pat_last, rgb_nxt;
    logic            unused_bits;

    // Stage 0: raster counters and per-pixel classification
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
        end else if (h_cnt_p0 == HC_W'(H_TOTAL - 1)) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= (v_cnt_p0 == VC_W'(V_TOTAL - 1)) ? '0 : v_cnt_p0 + VC_W'(1);
        end else begin
            h_cnt_p0 <= h_cnt_p0 + HC_W'(1);
        end
    end

    always_comb begin
        x_p0     = 16'(h_cnt_p0) - 16'(H_BP);
        y_p0     = 16'(v_cnt_p0) - 16'(V_BP);
        x_off_p0 = x_p0 - 16'(WIN_X);
        y_off_p0 = y_p0 - 16'(WIN_Y);
        hs_p0    = (h_cnt_p0 >= HC_W'(H_PULSE));
        vs_p0    = (v_cnt_p0 >= VC_W'(V_PULSE));
        den_p0   = (h_cnt_p0 >= HC_W'(H_BP)) && (h_cnt_p0 < HC_W'(H_BP + H_ACTIVE)) &&
                   (v_cnt_p0 >= VC_W'(V_BP)) && (v_cnt_p0 < VC_W'(V_BP + V_ACTIVE));
        // Out-of-window coordinates wrap to huge unsigned values, so plain compares suffice.
        win_p0   = den_p0 &&
                   (x_p0 >= 16'(WIN_X)) && (x_p0 < 16'(WIN_X + WIN_PX_W)) &&
                   (y_p0 >= 16'(WIN_Y)) && (y_p0 < 16'(WIN_Y + WIN_PX_H));
        fs_p0    = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    end

    // Only the texel-index bits of the offsets and the top six data bits are consumed.
    assign unused_bits = ^{x_off_p0, y_off_p0, bus.rd_data};

    // Stage 1: RAM address issue; mode/background latched at the frame origin only
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= 2'b00;
            bg_q        <= '0;
            ctrl_p1     <= CTRL_IDLE;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
        end else begin
            if (fs_p0) begin
                mode_q <= mode;
                bg_q   <= bg_color;
            end
            ctrl_p1   <= {fs_p0, hs_p0, vs_p0, den_p0, win_p0};
            bus.rd_en <= win_p0 && !mode_q[1];
            if (win_p0)
                bus.rd_addr <= {y_off_p0[SCALE_LOG2 +: WIN_H_LOG2],
                                x_off_p0[SCALE_LOG2 +: WIN_W_LOG2]};
        end
    end

    always_ff @(posedge clk) pat_p1 <= x_p0 + y_p0;

    // Stage 2: delay line matching the RAM read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_LAT; i++) ctrl_p2[i] <= CTRL_IDLE;
        end else begin
            ctrl_p2[0] <= ctrl_p1;
            for (int i = 1; i < RAM_LAT; i++) ctrl_p2[i] <= ctrl_p2[i-1];
        end
    end

    always_ff @(posedge clk) begin
        pat_p2[0] <= pat_p1;
        for (int i = 1; i < RAM_LAT; i++) pat_p2[i] <= pat_p2[i-1];
    end

    always_comb begin
        ctrl_last = ctrl_p2[RAM_LAT-1];
        pat_last  = pat_p2[RAM_LAT-1];
        rgb_nxt   = '0;
        if (ctrl_last[1]) begin
            if (ctrl_last[0] && !mode_q[1])
                rgb_nxt = grey_to_rgb565(bus.rd_data[DATA_W-1 -: 6]);
            else if (mode_q[0])
                rgb_nxt = bg_q;
            else
                rgb_nxt = pat_last;
        end
    end

    // Stage 3: registered LCD pins
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.lcd_hsync   <= 1'b1;
            bus.lcd_vsync   <= 1'b1;
            bus.lcd_den     <= 1'b0;
            bus.frame_start <= 1'b0;
            {bus.lcd_r, bus.lcd_g, bus.lcd_b} <= '0;
        end else begin
            bus.frame_start <= ctrl_last[4];
            bus.lcd_hsync   <= ctrl_last[3];
            bus.lcd_vsync   <= ctrl_last[2];
            bus.lcd_den     <= ctrl_last[1];
            {bus.lcd_r, bus.lcd_g, bus.lcd_b} <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_lcd_window_scanner.sv
// Scoreboard bench: four scanners (RAM_LAT 1..4) on a reduced raster, checked
// against a frame-arithmetic reference model under randomized mode/bg/reset stimulus.
module tb_lcd_window_scanner;
    localparam int H_ACTIVE = 40, H_BP = 6, H_FP = 4, H_PULSE = 2;
    localparam int V_ACTIVE = 20, V_BP = 3, V_FP = 2, V_PULSE = 1;
    localparam int WIN_X = 8, WIN_Y = 2, WIN_W_LOG2 = 3, WIN_H_LOG2 = 2, SCALE_LOG2 = 2;
    localparam int DATA_W = 8;
    localparam int H_TOTAL = H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_BP + V_ACTIVE + V_FP;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int AW      = WIN_W_LOG2 + WIN_H_LOG2;
    localparam int TEX_W   = 2 ** WIN_W_LOG2;
    localparam int TEX_H   = 2 ** WIN_H_LOG2;
    localparam int SCALE   = 2 ** SCALE_LOG2;
    localparam int NDUT    = 4;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        den;
        logic [15:0] rgb;
        logic        fs;
    } pix_t;

    typedef struct packed {
        logic          en;
        logic [AW-1:0] addr;
    } rd_t;

    localparam pix_t PIX_IDLE = {1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [15:0] bg_color = 16'h0000;
    int          checks = 0;
    int          errors = 0;

    pix_t pix_q [NDUT][$];
    rd_t  rd_q  [NDUT][$];

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_word(input int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    // Reference model: one entry per raster clock, derived from the frame position.
    int          t = 0;
    int          m_h, m_v, m_x, m_y, m_addr;
    bit          m_act, m_win, m_img;
    logic [1:0]  m_mode = 2'b00;
    logic [15:0] m_bg = 16'h0000;
    logic [7:0]  m_d;
    pix_t        m_p;
    rd_t         m_r;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NDUT; i++) begin
                pix_q[i].delete();
                rd_q[i].delete();
            end
            t = 0;
            m_mode = 2'b00;
            m_bg = 16'h0000;
        end else begin
            m_h = t % H_TOTAL;
            m_v = (t / H_TOTAL) % V_TOTAL;
            if (m_h == 0 && m_v == 0) begin
                m_mode = mode;
                m_bg   = bg_color;
            end
            m_x   = m_h - H_BP;
            m_y   = m_v - V_BP;
            m_act = (m_x >= 0) && (m_x < H_ACTIVE) && (m_y >= 0) && (m_y < V_ACTIVE);
            m_win = m_act && (m_x >= WIN_X) && (m_x < WIN_X + TEX_W * SCALE) &&
                    (m_y >= WIN_Y) && (m_y < WIN_Y + TEX_H * SCALE);
            m_img = (m_mode == 2'd0) || (m_mode == 2'd1);
            m_addr = m_win ? (((m_y - WIN_Y) / SCALE) % TEX_H) * TEX_W +
                             (((m_x - WIN_X) / SCALE) % TEX_W) : 0;
            m_p.hs  = (m_h >= H_PULSE);
            m_p.vs  = (m_v >= V_PULSE);
            m_p.den = m_act;
            m_p.fs  = (m_h == 0) && (m_v == 0);
            if (!m_act) begin
                m_p.rgb = 16'h0000;
            end else if (m_win && m_img) begin
                m_d = ram_word(m_addr);
                m_p.rgb = {5'(m_d / 8), 6'(m_d / 4), 5'(m_d / 8)};
            end else if (m_mode == 2'd1 || m_mode == 2'd3) begin
                m_p.rgb = m_bg;
            end else begin
                m_p.rgb = 16'(m_x + m_y);
            end
            m_r.en   = m_win && m_img;
            m_r.addr = AW'(m_addr);
            for (int i = 0; i < NDUT; i++) begin
                pix_q[i].push_back(m_p);
                rd_q[i].push_back(m_r);
            end
            t++;
        end
    end

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        localparam int LAT = g + 1;

        lcd_window_scanner_if #(.ADDR_W(AW), .DATA_W(DATA_W)) bus ();

        lcd_window_scanner #(
            .H_ACTIVE(H_ACTIVE), .H_BP(H_BP), .H_FP(H_FP), .H_PULSE(H_PULSE),
            .V_ACTIVE(V_ACTIVE), .V_BP(V_BP), .V_FP(V_FP), .V_PULSE(V_PULSE),
            .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W_LOG2(WIN_W_LOG2),
            .WIN_H_LOG2(WIN_H_LOG2), .SCALE_LOG2(SCALE_LOG2),
            .DATA_W(DATA_W), .RAM_LAT(LAT)
        ) dut (
            .clk(clk),
            .reset(reset),
            .mode(mode),
            .bg_color(bg_color),
            .bus(bus)
        );

        // Video RAM model with LAT clocks of read latency
        logic [DATA_W-1:0] ram_pipe [LAT];
        always @(posedge clk) begin
            ram_pipe[0] <= ram_word(int'(bus.rd_addr));
            for (int k = 1; k < LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
        end
        assign bus.rd_data = ram_pipe[LAT-1];

        int   cnt = -1;
        int   pix_n = 0;
        bit   started = 1'b0;
        pix_t got, want;
        rd_t  rwant;

        always @(negedge clk) begin
            got = {bus.lcd_hsync, bus.lcd_vsync, bus.lcd_den,
                   bus.lcd_r, bus.lcd_g, bus.lcd_b, bus.frame_start};
            if (reset) begin
                cnt = -1;
                started = 1'b0;
                pix_n = 0;
            end else begin
                cnt++;
                if (cnt == 0) begin
                    checks++;
                    if (got !== PIX_IDLE || bus.rd_en !== 1'b0 || bus.rd_addr !== '0) begin
                        errors++;
                        $display("FAIL idle[lat%0d] got pins=%h rd_en=%b rd_addr=%h want pins=%h rd_en=0 rd_addr=0",
                                 LAT, got, bus.rd_en, bus.rd_addr, PIX_IDLE);
                    end
                end else begin
                    checks++;
                    if (rd_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL rd[lat%0d] no expected entry at cnt=%0d got rd_en=%b", LAT, cnt, bus.rd_en);
                    end else begin
                        rwant = rd_q[g].pop_front();
                        if (bus.rd_en !== rwant.en || (rwant.en && bus.rd_addr !== rwant.addr)) begin
                            errors++;
                            $display("FAIL rd[lat%0d] t=%0d got en=%b addr=%h want en=%b addr=%h",
                                     LAT, cnt - 1, bus.rd_en, bus.rd_addr, rwant.en, rwant.addr);
                        end
                    end
                end
                if (!started) begin
                    if (got.fs) begin
                        checks++;
                        if (cnt != 2 + LAT) begin
                            errors++;
                            $display("FAIL fs_latency[lat%0d] got %0d want %0d", LAT, cnt, 2 + LAT);
                        end
                        started = 1'b1;
                    end else if (cnt == 2 + LAT + 8) begin
                        checks++;
                        errors++;
                        $display("FAIL fs_timeout[lat%0d] got no frame_start after %0d clocks want %0d",
                                 LAT, cnt, 2 + LAT);
                    end
                end
                if (started) begin
                    checks++;
                    if (pix_q[g].size() == 0) begin
                        errors++;
                        $display("FAIL pix[lat%0d] no expected entry at n=%0d got %h", LAT, pix_n, got);
                    end else begin
                        want = pix_q[g].pop_front();
                        if (got !== want) begin
                            errors++;
                            $display("FAIL pix[lat%0d] n=%0d got hs=%b vs=%b den=%b rgb=%h fs=%b want hs=%b vs=%b den=%b rgb=%h fs=%b",
                                     LAT, pix_n, got.hs, got.vs, got.den, got.rgb, got.fs,
                                     want.hs, want.vs, want.den, want.rgb, want.fs);
                        end
                    end
                    pix_n++;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        mode     = 2'b00;
        bg_color = 16'h1234;
        tick(3);
        reset = 1'b0;
        tick(2 * FRAME);
        // Mid-frame switch to solid red: takes effect from the next frame.
        tick(FRAME / 2);
        mode     = 2'b11;
        bg_color = 16'hF800;
        tick(2 * FRAME);
        mode = 2'b10;
        tick(2 * FRAME);
        mode = 2'b00;
        tick(FRAME + FRAME / 3);
        while ((t % H_TOTAL) != 30) tick(1);
        pulse_reset();
        tick(FRAME + 50);
        for (int k = 0; k < 12; k++) begin
            tick($urandom_range(20, FRAME));
            if ($urandom_range(0, 5) == 0) begin
                pulse_reset();
            end else begin
                mode     = 2'($urandom);
                bg_color = 16'($urandom);
            end
        end
        tick(FRAME + 20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
